// File: rtl/sram_pkg.sv
// ============================================================================
// Module      : sram_pkg
// Description : Shared widths, limits and FSM state encoding for the SRAM
//               burst packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_pkg;

    localparam int ADDR_W         = 8;
    localparam int WORD_W         = 16;
    localparam int BURST_MAX      = 8;
    localparam int TIMEOUT_CYCLES = 255;

    // Derived widths: burst_len holds words-1, the word counter must reach 8.
    localparam int LEN_W   = $clog2(BURST_MAX);
    localparam int CNT_W   = LEN_W + 1;
    localparam int BURST_W = WORD_W * BURST_MAX;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_REQ     = 2'd2
    } state_t;

endpackage : sram_pkg

`default_nettype wire

// File: rtl/sram_burst_packer_if.sv
// ============================================================================
// Module      : sram_burst_packer_if
// Description : Host beat stream, read return and SRAM controller request
//               bundle. The slave modport is the packer; the master modport is
//               the host/controller environment around it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_burst_packer_if;
    import sram_pkg::*;

    // Host side
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_rw;
    logic [ADDR_W-1:0]    in_addr;
    logic [WORD_W-1:0]    in_data;
    logic                 in_last;
    logic                 rd_valid;
    logic [WORD_W-1:0]    rd_data;

    // SRAM controller side
    logic                 req;
    logic                 rw;
    logic [ADDR_W-1:0]    addr;
    logic [WORD_W-1:0]    data_in;
    logic                 burst_en;
    logic [LEN_W-1:0]     burst_len;
    logic [BURST_W-1:0]   burst_data_in;
    logic                 ready;
    logic [WORD_W-1:0]    data_out;
    logic                 err;

    modport slave (
        input  in_valid, in_rw, in_addr, in_data, in_last, ready, data_out,
        output in_ready, rd_valid, rd_data, req, rw, addr, data_in,
               burst_en, burst_len, burst_data_in, err
    );

    modport master (
        output in_valid, in_rw, in_addr, in_data, in_last, ready, data_out,
        input  in_ready, rd_valid, rd_data, req, rw, addr, data_in,
               burst_en, burst_len, burst_data_in, err
    );

endinterface : sram_burst_packer_if

`default_nettype wire

// File: rtl/sram_burst_packer.sv
// ============================================================================
// Module      : sram_burst_packer
// Description : Packs host write beats into single or burst SRAM controller
//               requests (up to 8 words), forwards reads one at a time and
//               returns read data as a one-cycle strobe.
//               Optional feature macro: SRAM_PACKER_TIMEOUT_EN adds an 8-bit
//               REQ watchdog that abandons a request and pulses err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_burst_packer
    import sram_pkg::*;
(
    input  wire logic           clk,
    input  wire logic           reset,
    sram_burst_packer_if.slave  bus
);

    state_t                 r_state;
    logic                   r_req;
    logic                   r_rw;
    logic [ADDR_W-1:0]      r_addr;
    logic [WORD_W-1:0]      r_data_in;
    logic                   r_burst_en;
    logic [LEN_W-1:0]       r_burst_len;
    logic [BURST_W-1:0]     r_burst_data;
    logic                   r_rd_valid;
    logic [WORD_W-1:0]      r_rd_data;
    logic [CNT_W-1:0]       r_count;

    state_t                 w_state_nxt;
    logic                   w_req_nxt;
    logic                   w_rw_nxt;
    logic [ADDR_W-1:0]      w_addr_nxt;
    logic [WORD_W-1:0]      w_data_in_nxt;
    logic                   w_burst_en_nxt;
    logic [LEN_W-1:0]       w_burst_len_nxt;
    logic [BURST_W-1:0]     w_burst_data_nxt;
    logic                   w_rd_valid_nxt;
    logic [WORD_W-1:0]      w_rd_data_nxt;
    logic [CNT_W-1:0]       w_count_nxt;
    logic                   w_timeout;

    // Host may push beats while idle, or more writes while a burst is open.
    assign bus.in_ready = (r_state == ST_IDLE) ||
                          ((r_state == ST_COLLECT) && !bus.in_rw);

    assign bus.req           = r_req;
    assign bus.rw            = r_rw;
    assign bus.addr          = r_addr;
    assign bus.data_in       = r_data_in;
    assign bus.burst_en      = r_burst_en;
    assign bus.burst_len     = r_burst_len;
    assign bus.burst_data_in = r_burst_data;
    assign bus.rd_valid      = r_rd_valid;
    assign bus.rd_data       = r_rd_data;

`ifdef SRAM_PACKER_TIMEOUT_EN
    localparam logic [7:0] c_TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_timer;
    logic       r_err;

    // Fires in the last allowed REQ cycle if the controller still has not answered.
    assign w_timeout = (r_state == ST_REQ) && !bus.ready && (r_timer == c_TIMER_LAST);
    assign bus.err   = r_err;

    // Count consecutive REQ cycles; cleared whenever the request ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if ((r_state == ST_REQ) && !w_timeout) begin
                r_timer <= r_timer + 8'd1;
            end else begin
                r_timer <= '0;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign bus.err   = 1'b0;
`endif

    // Next-state and next-output decode; every field holds unless changed below.
    always_comb begin
        w_state_nxt      = r_state;
        w_req_nxt        = r_req;
        w_rw_nxt         = r_rw;
        w_addr_nxt       = r_addr;
        w_data_in_nxt    = r_data_in;
        w_burst_en_nxt   = r_burst_en;
        w_burst_len_nxt  = r_burst_len;
        w_burst_data_nxt = r_burst_data;
        w_rd_valid_nxt   = 1'b0;
        w_rd_data_nxt    = r_rd_data;
        w_count_nxt      = r_count;

        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_addr_nxt       = bus.in_addr;
                    w_rw_nxt         = bus.in_rw;
                    w_burst_en_nxt   = 1'b0;
                    w_burst_len_nxt  = '0;
                    w_burst_data_nxt = '0;
                    if (bus.in_rw) begin
                        w_count_nxt = '0;
                        w_state_nxt = ST_REQ;
                        w_req_nxt   = 1'b1;
                    end else begin
                        // Word 0 goes to both the single-word and lane-0 slots.
                        w_data_in_nxt                 = bus.in_data;
                        w_burst_data_nxt[WORD_W-1:0]  = bus.in_data;
                        w_count_nxt                   = CNT_W'(1);
                        if (bus.in_last) begin
                            w_state_nxt = ST_REQ;
                            w_req_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = ST_COLLECT;
                        end
                    end
                end
            end

            ST_COLLECT: begin
                if (bus.in_valid && bus.in_rw) begin
                    // A waiting read flushes whatever has been gathered so far.
                    w_burst_en_nxt  = (r_count >= CNT_W'(2));
                    w_burst_len_nxt = LEN_W'(r_count - CNT_W'(1));
                    w_state_nxt     = ST_REQ;
                    w_req_nxt       = 1'b1;
                end else if (bus.in_valid) begin
                    w_burst_data_nxt[r_count[LEN_W-1:0]*WORD_W +: WORD_W] = bus.in_data;
                    w_count_nxt = r_count + CNT_W'(1);
                    if (bus.in_last || (r_count == CNT_W'(BURST_MAX - 1))) begin
                        w_burst_en_nxt  = 1'b1;
                        w_burst_len_nxt = LEN_W'(r_count);
                        w_state_nxt     = ST_REQ;
                        w_req_nxt       = 1'b1;
                    end
                end
            end

            ST_REQ: begin
                if (bus.ready) begin
                    w_req_nxt   = 1'b0;
                    w_count_nxt = '0;
                    w_state_nxt = ST_IDLE;
                    if (r_rw) begin
                        w_rd_valid_nxt = 1'b1;
                        w_rd_data_nxt  = bus.data_out;
                    end
                end else if (w_timeout) begin
                    w_req_nxt   = 1'b0;
                    w_count_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    // State and all registered outputs; reset drops any partial or pending request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_req        <= 1'b0;
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_data_in    <= '0;
            r_burst_en   <= 1'b0;
            r_burst_len  <= '0;
            r_burst_data <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_count      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_req        <= w_req_nxt;
            r_rw         <= w_rw_nxt;
            r_addr       <= w_addr_nxt;
            r_data_in    <= w_data_in_nxt;
            r_burst_en   <= w_burst_en_nxt;
            r_burst_len  <= w_burst_len_nxt;
            r_burst_data <= w_burst_data_nxt;
            r_rd_valid   <= w_rd_valid_nxt;
            r_rd_data    <= w_rd_data_nxt;
            r_count      <= w_count_nxt;
        end
    end

endmodule : sram_burst_packer

`default_nettype wire

// File: tb/tb_sram_burst_packer.sv
// ============================================================================
// Module      : tb_sram_burst_packer
// Description : Self-checking bench for sram_burst_packer. Host beats are
//               recorded as accepted; a transaction-level model turns them
//               into the expected request list, compared against requests
//               captured by a responding controller model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_burst_packer;

    typedef struct packed {
        logic         rw;
        logic [7:0]   addr;
        logic [15:0]  data;
        logic         last;
    } beat_t;

    typedef struct packed {
        logic         rw;
        logic [7:0]   addr;
        logic         be;
        logic [2:0]   len;
        logic [15:0]  d;
        logic [127:0] bd;
    } req_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sram_burst_packer_if bus();

    sram_burst_packer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    beat_t  beats[$];
    req_t   obs[$];
    req_t   exp_q[$];
    bit     ctl_hold = 1'b0;
    bit     ctl_busy = 1'b0;
    bit     use_beef = 1'b0;
    bit     spur_req = 1'b0;
    bit     err_seen = 1'b0;
    bit     rnd_rw;

    task automatic chk_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic req_t cur_req();
        req_t r;
        r.rw   = bus.rw;
        r.addr = bus.addr;
        r.be   = bus.burst_en;
        r.len  = bus.burst_len;
        r.d    = bus.data_in;
        r.bd   = bus.burst_data_in;
        return r;
    endfunction

    // One write request from a group of gathered words.
    function automatic req_t make_write(input logic [7:0] a, input logic [15:0] w[$]);
        req_t r;
        r      = '0;
        r.addr = a;
        if (w.size() == 1) begin
            r.d = w[0];
        end else begin
            r.be  = 1'b1;
            r.len = 3'(w.size() - 1);
            foreach (w[k]) r.bd[16*k +: 16] = w[k];
        end
        return r;
    endfunction

    // Transaction-level reference: a write group opens on its first beat and
    // closes on in_last, on the 8th word, or when a read beat arrives.
    function automatic void build_model(output req_t q[$]);
        logic [15:0] words[$];
        logic [7:0]  gaddr;
        req_t        r;
        q     = {};
        gaddr = '0;
        foreach (beats[i]) begin
            if (beats[i].rw) begin
                if (words.size() > 0) begin
                    q.push_back(make_write(gaddr, words));
                    words = {};
                end
                r      = '0;
                r.rw   = 1'b1;
                r.addr = beats[i].addr;
                q.push_back(r);
            end else begin
                if (words.size() == 0) gaddr = beats[i].addr;
                words.push_back(beats[i].data);
                if (beats[i].last || words.size() == 8) begin
                    q.push_back(make_write(gaddr, words));
                    words = {};
                end
            end
        end
    endfunction

    task automatic check_all_zero(input string tag);
        chk_val({tag, "_req"},   bus.req, 0);
        chk_val({tag, "_rw"},    bus.rw, 0);
        chk_val({tag, "_addr"},  bus.addr, 0);
        chk_val({tag, "_din"},   bus.data_in, 0);
        chk_val({tag, "_ben"},   bus.burst_en, 0);
        chk_val({tag, "_blen"},  bus.burst_len, 0);
        chk_val({tag, "_bdata"}, bus.burst_data_in, 0);
        chk_val({tag, "_rdv"},   bus.rd_valid, 0);
        chk_val({tag, "_rdd"},   bus.rd_data, 0);
        chk_val({tag, "_err"},   bus.err, 0);
    endtask

    task automatic drive_beat(input bit rw, input logic [7:0] a, input logic [15:0] d, input bit last);
        bus.in_valid = 1'b1;
        bus.in_rw    = rw;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.in_last  = last;
    endtask

    // Returns #1 after the edge that accepted the beat.
    task automatic wait_accept();
        int k;
        bit acc;
        k   = 0;
        acc = 1'b0;
        while (!acc && k < 600) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            k++;
        end
        if (!acc) begin
            chk_val("accept_timeout", acc, 1);
        end else begin
            beats.push_back({bus.in_rw, bus.in_addr, bus.in_data, bus.in_last});
            if (bus.in_rw || bus.in_last) chk_val("latency_req", bus.req, 1);
        end
    endtask

    task automatic send_beat(input bit rw, input logic [7:0] a, input logic [15:0] d, input bit last);
        drive_beat(rw, a, d, last);
        wait_accept();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        bus.in_valid = 1'b0;
        while ((bus.req || ctl_busy) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk_val("idle_reached", k < 300, 1);
        @(posedge clk);
        #1;
    endtask

`ifndef SRAM_PACKER_TIMEOUT_EN
    always @(negedge clk) if (bus.err === 1'b1) err_seen = 1'b1;
`endif

    // SRAM controller model: captures each request, answers after 0-3 cycles.
    initial begin : p_ctrl
        req_t        snap;
        int          d;
        logic [15:0] dat;
        bit          rd_chk;
        bus.ready    = 1'b0;
        bus.data_out = '0;
        rd_chk       = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_chk) begin
                chk_val("rd_pulse_width", bus.rd_valid, 0);
                rd_chk = 1'b0;
            end
            if (spur_req && !bus.req) begin
                bus.ready    = 1'b1;
                bus.data_out = 16'h5A5A;
                @(posedge clk);
                #1;
                bus.ready = 1'b0;
                chk_val("spur_req", bus.req, 0);
                chk_val("spur_rdv", bus.rd_valid, 0);
                spur_req = 1'b0;
            end else if (reset && bus.req && !ctl_hold) begin
                ctl_busy = 1'b1;
                snap     = cur_req();
                obs.push_back(snap);
                d = $urandom_range(0, 3);
                repeat (d) begin
                    @(posedge clk);
                    #1;
                    chk_val("req_hold", bus.req, 1);
                    chk_val("fields_hold", cur_req() == snap, 1);
                    chk_val("in_ready_in_req", bus.in_ready, 0);
                end
                dat          = use_beef ? 16'hBEEF : 16'($urandom);
                bus.data_out = dat;
                bus.ready    = 1'b1;
                @(posedge clk);
                #1;
                bus.ready    = 1'b0;
                bus.data_out = 16'($urandom);
                chk_val("req_drop", bus.req, 0);
                chk_val("rd_valid", bus.rd_valid, snap.rw);
                if (snap.rw) chk_val("rd_data", bus.rd_data, dat);
                rd_chk   = 1'b1;
                ctl_busy = 1'b0;
            end
        end
    end

    initial begin : p_main
        bus.in_valid = 1'b0;
        bus.in_rw    = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        chk_val("rst_in_ready", bus.in_ready, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single write
        send_beat(0, 8'h10, 16'hAAAA, 1);
        bus.in_valid = 1'b0;
        chk_val("sw_rw", bus.rw, 0);
        chk_val("sw_ben", bus.burst_en, 0);
        chk_val("sw_addr", bus.addr, 8'h10);
        chk_val("sw_din", bus.data_in, 16'hAAAA);
        wait_idle();

        // Three-word burst, addresses of later beats ignored
        send_beat(0, 8'h20, 16'h1111, 0);
        send_beat(0, 8'($urandom), 16'h2222, 0);
        send_beat(0, 8'($urandom), 16'h3333, 1);
        bus.in_valid = 1'b0;
        chk_val("b3_ben", bus.burst_en, 1);
        chk_val("b3_len", bus.burst_len, 2);
        chk_val("b3_addr", bus.addr, 8'h20);
        chk_val("b3_data", bus.burst_data_in, 128'h3333_2222_1111);
        wait_idle();

        // Eight words without in_last close on the 8th
        for (int i = 0; i < 8; i++) send_beat(0, 8'h30, 16'(16'h0100 + i), 0);
        chk_val("b8_req", bus.req, 1);
        chk_val("b8_len", bus.burst_len, 7);
        chk_val("b8_data", bus.burst_data_in,
                128'h0107_0106_0105_0104_0103_0102_0101_0100);
        drive_beat(0, 8'h31, 16'hCAFE, 1);
        @(negedge clk);
        chk_val("b8_blocked", bus.in_ready, 0);
        wait_accept();
        wait_idle();

        // Read with controller data 0xBEEF
        use_beef = 1'b1;
        send_beat(1, 8'h40, 16'h0000, 0);
        bus.in_valid = 1'b0;
        chk_val("rd_rw", bus.rw, 1);
        chk_val("rd_addr", bus.addr, 8'h40);
        chk_val("rd_ben", bus.burst_en, 0);
        wait_idle();
        use_beef = 1'b0;

        // Two writes then a read beat: read flushes a 2-word burst first
        send_beat(0, 8'h50, 16'h5151, 0);
        send_beat(0, 8'h55, 16'h5252, 0);
        drive_beat(1, 8'h60, 16'h0000, 0);
        @(negedge clk);
        chk_val("rdint_not_acc", bus.in_ready, 0);
        @(posedge clk);
        #1;
        chk_val("rdint_req", bus.req, 1);
        chk_val("rdint_rw", bus.rw, 0);
        chk_val("rdint_len", bus.burst_len, 1);
        chk_val("rdint_data", bus.burst_data_in, 128'h5252_5151);
        wait_accept();
        bus.in_valid = 1'b0;
        chk_val("rdint_rd_rw", bus.rw, 1);
        chk_val("rdint_rd_addr", bus.addr, 8'h60);
        wait_idle();

        // ready while idle is ignored
        spur_req = 1'b1;
        for (int k = 0; k < 10 && spur_req; k++) begin
            @(posedge clk);
            #1;
        end
        chk_val("spur_done", spur_req, 0);

        // Reset mid-COLLECT
        send_beat(0, 8'h70, 16'h7070, 0);
        send_beat(0, 8'h71, 16'h7171, 0);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_all_zero("rstc");
        @(posedge clk);
        #1;
        reset = 1'b1;
        void'(beats.pop_back());
        void'(beats.pop_back());
        repeat (3) @(posedge clk);
        #1;
        chk_val("rstc_noreq", bus.req, 0);

        // Reset mid-REQ, no replay
        ctl_hold = 1'b1;
        send_beat(0, 8'h72, 16'h7272, 1);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_all_zero("rstr");
        @(posedge clk);
        #1;
        reset = 1'b1;
        void'(beats.pop_back());
        ctl_hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_val("rstr_noreq", bus.req, 0);

`ifdef SRAM_PACKER_TIMEOUT_EN
        // Withheld ready: request abandoned after 255 cycles with an err pulse
        ctl_hold = 1'b1;
        send_beat(0, 8'h77, 16'h1234, 1);
        bus.in_valid = 1'b0;
        begin
            int hi;
            hi = 0;
            while (bus.req && hi < 400) begin
                hi++;
                @(posedge clk);
                #1;
            end
            chk_val("to_cycles", hi, 255);
            chk_val("to_err", bus.err, 1);
            chk_val("to_req", bus.req, 0);
            chk_val("to_rdv", bus.rd_valid, 0);
            @(posedge clk);
            #1;
            chk_val("to_err_pulse", bus.err, 0);
        end
        void'(beats.pop_back());
        ctl_hold = 1'b0;
`endif

        // Random beat stream
        for (int i = 0; i < 150; i++) begin
            rnd_rw = ($urandom_range(0, 4) == 0);
            send_beat(rnd_rw, 8'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 4) == 0) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        send_beat(1, 8'h99, 16'h0000, 0);
        wait_idle();

        // Whole-run request list against the transaction model
        build_model(exp_q);
        chk_val("req_count", obs.size(), exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            chk_val($sformatf("req%0d_rw", i), obs[i].rw, exp_q[i].rw);
            chk_val($sformatf("req%0d_addr", i), obs[i].addr, exp_q[i].addr);
            chk_val($sformatf("req%0d_ben", i), obs[i].be, exp_q[i].be);
            if (!exp_q[i].rw) begin
                if (exp_q[i].be) begin
                    chk_val($sformatf("req%0d_len", i), obs[i].len, exp_q[i].len);
                    chk_val($sformatf("req%0d_bdata", i), obs[i].bd, exp_q[i].bd);
                end else begin
                    chk_val($sformatf("req%0d_din", i), obs[i].d, exp_q[i].d);
                end
            end
        end
`ifndef SRAM_PACKER_TIMEOUT_EN
        chk_val("err_tied_low", err_seen, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin : p_watchdog
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "time limit");
    end

endmodule : tb_sram_burst_packer

`default_nettype wire
